// File: rtl/seg7_scan_mux_if.sv
// Display-value load bus and 7-segment pin bundle for seg7_scan_mux.
interface seg7_scan_mux_if;
    logic [31:0] data_i;
    logic [7:0]  dp_i;
    logic [7:0]  en_i;
    logic        load_i;
    logic [6:0]  hex;
    logic        DP;
    logic [7:0]  AN;
    logic        frame_o;

    modport master (
        output data_i, dp_i, en_i, load_i,
        input  hex, DP, AN, frame_o
    );

    modport slave (
        input  data_i, dp_i, en_i, load_i,
        output hex, DP, AN, frame_o
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 8-digit common-anode 7-segment driver with frame-aligned,
// tear-free value updates and optional leading-zero blanking.
module seg7_scan_mux #(
    parameter int unsigned DIV      = 100000,
    parameter int unsigned BLANK    = 64,
    parameter int unsigned BLANK_LZ = 0
) (
    input  logic            clk,
    input  logic            rst,
    seg7_scan_mux_if.slave  bus
);
    localparam int unsigned CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;

    logic [31:0] pend_data;
    logic [7:0]  pend_dp;
    logic [7:0]  pend_en;
    logic        pend_flag;

    logic [31:0] act_data;
    logic [7:0]  act_dp;
    logic [7:0]  act_en;

    logic        slot_end_c;
    logic        wrap_c;
    logic [3:0]  nib_c;
    logic [7:0]  upper_zero_c;
    logic        lz_blank_c;
    logic        lit_c;

    function automatic logic [6:0] dec(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h7F;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign slot_end_c = (cnt == CNT_LAST);
    assign wrap_c     = slot_end_c && (idx == 3'd7);
    assign nib_c      = act_data[{idx, 2'b00} +: 4];

    // upper_zero_c[i]: active nibbles i..7 are all zero
    always_comb begin
        upper_zero_c = '0;
        for (int i = 0; i < 8; i++) begin
            upper_zero_c[i] = 1'b1;
            for (int j = i; j < 8; j++) begin
                if (act_data[4*j +: 4] != 4'h0) begin
                    upper_zero_c[i] = 1'b0;
                end
            end
        end
    end

    assign lz_blank_c = (BLANK_LZ != 0) && (idx != 3'd0) && upper_zero_c[idx];
    assign lit_c      = act_en[idx] && !(cnt < CNT_BLANK) && !lz_blank_c;

    // Prescaler and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end_c) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Pending/active value registers; active only changes on the frame wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_data <= '0;
            pend_dp   <= '0;
            pend_en   <= '0;
            pend_flag <= 1'b0;
            act_data  <= '0;
            act_dp    <= '0;
            act_en    <= '0;
        end else if (wrap_c) begin
            if (bus.load_i) begin
                act_data  <= bus.data_i;
                act_dp    <= bus.dp_i;
                act_en    <= bus.en_i;
                pend_flag <= 1'b0;
            end else if (pend_flag) begin
                act_data  <= pend_data;
                act_dp    <= pend_dp;
                act_en    <= pend_en;
                pend_flag <= 1'b0;
            end
        end else if (bus.load_i) begin
            pend_data <= bus.data_i;
            pend_dp   <= bus.dp_i;
            pend_en   <= bus.en_i;
            pend_flag <= 1'b1;
        end
    end

    // Registered pin drive
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.AN      <= 8'hFF;
            bus.hex     <= 7'h7F;
            bus.DP      <= 1'b1;
            bus.frame_o <= 1'b0;
        end else begin
            bus.frame_o <= wrap_c;
            if (lit_c) begin
                bus.AN  <= ~(8'b1 << idx);
                bus.hex <= dec(nib_c);
                bus.DP  <= ~act_dp[idx];
            end else begin
                bus.AN  <= 8'hFF;
                bus.hex <= 7'h7F;
                bus.DP  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: two instances (leading-zero blanking off/on) checked
// every cycle against an arithmetic timeline model, plus directed spot checks.
module tb_seg7_scan_mux;
    localparam int unsigned DIV   = 4;
    localparam int unsigned BLANK = 1;
    localparam int FRAME = 8 * DIV;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_scan_mux_if if0 ();
    seg7_scan_mux_if if1 ();

    seg7_scan_mux #(.DIV(DIV), .BLANK(BLANK), .BLANK_LZ(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    seg7_scan_mux #(.DIV(DIV), .BLANK(BLANK), .BLANK_LZ(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave));

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [31:0] d_data = '0;
    logic [7:0]  d_dp   = '0;
    logic [7:0]  d_en   = '0;
    logic        d_load = 1'b0;

    // Reference state: time within the scan since reset, shown and queued values
    int          m_t = 0;
    logic [31:0] m_data = '0;
    logic [7:0]  m_dp = '0;
    logic [7:0]  m_en = '0;
    bit          m_has_pend = 1'b0;
    logic [31:0] m_pdata = '0;
    logic [7:0]  m_pdp = '0;
    logic [7:0]  m_pen = '0;

    logic [6:0] seg_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, obs, exp);
        end
    endtask

    function automatic void model_out(input bit lz, output logic [7:0] an,
                                      output logic [6:0] hx, output logic dp);
        int  c, d;
        bit  lit;
        logic [31:0] upper;
        c = m_t % DIV;
        d = (m_t / DIV) % 8;
        upper = m_data >> (4 * d);
        lit = m_en[d] && (c >= BLANK) && !(lz && d != 0 && upper == 32'h0);
        if (lit) begin
            an = 8'hFF;
            an[d] = 1'b0;
            hx = seg_tbl[upper[3:0]];
            dp = ~m_dp[d];
        end else begin
            an = 8'hFF;
            hx = 7'h7F;
            dp = 1'b1;
        end
    endfunction

    // One clock: predict, advance model, clock DUTs, compare
    task automatic tick();
        logic [7:0] e_an [2];
        logic [6:0] e_hx [2];
        logic       e_dp [2];
        logic       e_fr;
        bit         wrap;
        if0.data_i = d_data; if0.dp_i = d_dp; if0.en_i = d_en; if0.load_i = d_load;
        if1.data_i = d_data; if1.dp_i = d_dp; if1.en_i = d_en; if1.load_i = d_load;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                e_an[k] = 8'hFF; e_hx[k] = 7'h7F; e_dp[k] = 1'b1;
            end
            e_fr = 1'b0;
            m_t = 0; m_data = '0; m_dp = '0; m_en = '0;
            m_has_pend = 1'b0; m_pdata = '0; m_pdp = '0; m_pen = '0;
        end else begin
            for (int k = 0; k < 2; k++) model_out(k == 1, e_an[k], e_hx[k], e_dp[k]);
            wrap = (m_t % FRAME) == FRAME - 1;
            e_fr = wrap;
            if (wrap && d_load) begin
                m_data = d_data; m_dp = d_dp; m_en = d_en; m_has_pend = 1'b0;
            end else if (wrap && m_has_pend) begin
                m_data = m_pdata; m_dp = m_pdp; m_en = m_pen; m_has_pend = 1'b0;
            end else if (d_load) begin
                m_pdata = d_data; m_pdp = d_dp; m_pen = d_en; m_has_pend = 1'b1;
            end
            m_t++;
        end
        @(posedge clk);
        #1;
        chk("dut0.AN",    32'(if0.AN),      32'(e_an[0]));
        chk("dut0.hex",   32'(if0.hex),     32'(e_hx[0]));
        chk("dut0.DP",    32'(if0.DP),      32'(e_dp[0]));
        chk("dut0.frame", 32'(if0.frame_o), 32'(e_fr));
        chk("dut1.AN",    32'(if1.AN),      32'(e_an[1]));
        chk("dut1.hex",   32'(if1.hex),     32'(e_hx[1]));
        chk("dut1.DP",    32'(if1.DP),      32'(e_dp[1]));
        chk("dut1.frame", 32'(if1.frame_o), 32'(e_fr));
    endtask

    task automatic do_load(input logic [31:0] data, input logic [7:0] dp, input logic [7:0] en);
        d_data = data; d_dp = dp; d_en = en; d_load = 1'b1;
        tick();
        d_load = 1'b0;
    endtask

    task automatic run_to(input int target);
        for (int g = 0; g < 4000 && m_t < target; g++) tick();
    endtask

    initial begin
        rst = 1'b1;
        // reset held three cycles
        repeat (3) begin
            tick();
            chk("rst.AN",    32'(if0.AN),      32'h0000_00FF);
            chk("rst.hex",   32'(if0.hex),     32'h0000_007F);
            chk("rst.DP",    32'(if0.DP),      32'h1);
            chk("rst.frame", 32'(if0.frame_o), 32'h0);
        end
        rst = 1'b0;

        // first load stays queued until the frame wrap
        do_load(32'h0123_4567, 8'h01, 8'hFF);
        run_to(30);
        chk("preload.AN", 32'(if0.AN), 32'h0000_00FF);
        run_to(34);
        chk("d0.AN",  32'(if0.AN),  32'h0000_00FE);
        chk("d0.hex", 32'(if0.hex), 32'(7'b1111000));
        chk("d0.DP",  32'(if0.DP),  32'h0);
        run_to(61);
        chk("blank.AN", 32'(if0.AN), 32'h0000_00FF);
        run_to(62);
        chk("d7.AN",  32'(if0.AN),  32'h0000_007F);
        chk("d7.hex", 32'(if0.hex), 32'(7'b1000000));
        chk("d7.DP",  32'(if0.DP),  32'h1);

        // free run, then two loads in one frame: last wins, old shown until wrap
        run_to(165);
        do_load(32'hFFFF_FFFF, 8'h00, 8'hFF);
        run_to(180);
        do_load(32'h8888_8888, 8'h00, 8'hFF);
        run_to(190);
        chk("old.AN",  32'(if0.AN),  32'h0000_007F);
        chk("old.hex", 32'(if0.hex), 32'(7'b1000000));
        run_to(194);
        chk("new8.AN",  32'(if0.AN),  32'h0000_00FE);
        chk("new8.hex", 32'(if0.hex), 32'(7'b0000000));

        // leading-zero blanking
        do_load(32'h0000_00A0, 8'h00, 8'hFF);
        run_to(230);
        chk("lz.d1.AN",  32'(if1.AN),  32'h0000_00FD);
        chk("lz.d1.hex", 32'(if1.hex), 32'(7'b0001000));
        run_to(234);
        chk("lz.d2.AN",  32'(if1.AN),  32'h0000_00FF);
        chk("nolz.d2.AN", 32'(if0.AN), 32'h0000_00FB);
        do_load(32'h0000_0000, 8'h00, 8'hFF);
        run_to(258);
        chk("lz0.d0.AN",  32'(if1.AN),  32'h0000_00FE);
        chk("lz0.d0.hex", 32'(if1.hex), 32'(7'b1000000));
        run_to(262);
        chk("lz0.d1.AN", 32'(if1.AN), 32'h0000_00FF);

        // load exactly on the wrap cycle goes straight to the next frame
        run_to(287);
        do_load(32'h89AB_CDEF, 8'hFF, 8'hFF);
        run_to(290);
        chk("wrapld.AN",  32'(if0.AN),  32'h0000_00FE);
        chk("wrapld.hex", 32'(if0.hex), 32'(7'b0001110));
        chk("wrapld.DP",  32'(if0.DP),  32'h0);

        // mid-slot reset discards a queued load
        run_to(300);
        do_load(32'h1111_1111, 8'h00, 8'hFF);
        run_to(302);
        rst = 1'b1;
        tick();
        chk("midrst.AN", 32'(if0.AN), 32'h0000_00FF);
        rst = 1'b0;
        run_to(34);
        chk("postrst.AN", 32'(if0.AN), 32'h0000_00FF);

        // randomized loads, occasional resets
        for (int i = 0; i < 900; i++) begin
            d_data = $urandom() >> (4 * $urandom_range(0, 8));
            d_dp   = 8'($urandom());
            d_en   = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'hFF;
            d_load = ($urandom_range(0, 15) == 0);
            rst    = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        d_load = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
